// File: rtl/multi_edge_detector_if.sv
// -----------------------------------------------------------------------------
// multi_edge_detector_if
// Groups the per-channel inputs and the event outputs of multi_edge_detector.
//   level    [N]     asynchronous level inputs, bit i = channel i
//   mode     [2N]    per-channel select {falling_en, rising_en} at [2i+1:2i]
//   clr      [N]     per-channel pending clear (level-sensitive)
//   cnt_clr          event counter clear
//   tick     [N]     one-cycle event pulse per channel
//   edge_pol [N]     polarity of the event, 1 = rising (valid with tick)
//   pend     [N]     sticky per-channel event flag
//   evt_cnt  [CNT_W] saturating total event count
// master drives the inputs and observes the outputs; slave is the detector.
// -----------------------------------------------------------------------------
interface multi_edge_detector_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic [N-1:0]     level;
  logic [2*N-1:0]   mode;
  logic [N-1:0]     clr;
  logic             cnt_clr;
  logic [N-1:0]     tick;
  logic [N-1:0]     edge_pol;
  logic [N-1:0]     pend;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output level, mode, clr, cnt_clr,
    input  tick, edge_pol, pend, evt_cnt
  );

  modport slave (
    input  level, mode, clr, cnt_clr,
    output tick, edge_pol, pend, evt_cnt
  );
endinterface

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
// N independent channels, each: synchroniser chain -> glitch filter -> edge
// detector with per-channel mode, sticky pending flag; a shared saturating
// counter totals all reported events.
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous active-high reset
//   bus    slave side of multi_edge_detector_if (level/mode/clr/cnt_clr in,
//          tick/edge_pol/pend/evt_cnt out)
// Latency from a clean level change (first sampled at edge E1) to tick is
// SYNC_STAGES + FILT_LEN edges.
// -----------------------------------------------------------------------------
module multi_edge_detector #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_edge_detector_if.slave   bus
);

  // Filter counter only needs to reach FILT_LEN-1 before acceptance.
  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

  // Counter arithmetic is done 6 bits wider so base + popcount (<= 32)
  // can never overflow before the saturation compare.
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [N-1:0]     tick_q,     tick_d;
  logic [N-1:0]     edge_pol_q, edge_pol_d;
  logic [N-1:0]     pend_q,     pend_d;
  logic [CNT_W-1:0] evt_cnt_q,  evt_cnt_d;

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FC_W-1:0]        fc_q,   fc_d;
    logic                   sync_lvl;
    logic                   accept;
    logic [1:0]             ch_mode;
    logic                   ch_tick_d;
    logic                   ch_pol_d;
    logic                   ch_pend_d;

    // Bit 0 of the chain takes the raw input; the MSB is the synchronised level.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.level[gi]};
    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign ch_mode  = bus.mode[2*gi +: 2];

    // Glitch filter: a new level must be seen on FILT_LEN consecutive edges.
    // Any edge where sync matches filt restarts the count, so short
    // excursions never reach acceptance.
    always_comb begin
      filt_d = filt_q;
      fc_d   = fc_q;
      accept = 1'b0;
      if (sync_lvl == filt_q) begin
        fc_d = '0;
      end else if (fc_q == FC_LAST) begin
        filt_d = sync_lvl;
        fc_d   = '0;
        accept = 1'b1;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    // Mode is looked at only on the acceptance edge. filt tracks the input
    // regardless of mode, so enabling a channel later cannot fire on a
    // stale difference.
    always_comb begin
      ch_tick_d = 1'b0;
      ch_pol_d  = edge_pol_q[gi];
      if (accept) begin
        if (sync_lvl && ch_mode[0]) begin
          ch_tick_d = 1'b1;
          ch_pol_d  = 1'b1;
        end else if (!sync_lvl && ch_mode[1]) begin
          ch_tick_d = 1'b1;
          ch_pol_d  = 1'b0;
        end
      end
    end

    // Setting wins over clearing on the same edge.
    always_comb begin
      ch_pend_d = pend_q[gi];
      if (ch_tick_d) begin
        ch_pend_d = 1'b1;
      end else if (bus.clr[gi]) begin
        ch_pend_d = 1'b0;
      end
    end

    assign tick_d[gi]     = ch_tick_d;
    assign edge_pol_d[gi] = ch_pol_d;
    assign pend_d[gi]     = ch_pend_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
        filt_q <= 1'b0;
        fc_q   <= '0;
      end else begin
        sync_q <= sync_d;
        filt_q <= filt_d;
        fc_q   <= fc_d;
      end
    end
  end : g_ch

  // ---------------------------------------------------------------------------
  // Event counter: adds the ticks currently on the outputs, so each reported
  // pulse is counted exactly once on the edge after it appears.
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] tick_pop;
  logic [SUM_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;

  always_comb begin
    tick_pop = '0;
    for (int i = 0; i < N; i++) begin
      tick_pop = tick_pop + SUM_W'(tick_q[i]);
    end
    cnt_base = bus.cnt_clr ? '0 : SUM_W'(evt_cnt_q);
    cnt_sum  = cnt_base + tick_pop;
    if (cnt_sum > CNT_MAX) begin
      evt_cnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      evt_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q     <= '0;
      edge_pol_q <= '0;
      pend_q     <= '0;
      evt_cnt_q  <= '0;
    end else begin
      tick_q     <= tick_d;
      edge_pol_q <= edge_pol_d;
      pend_q     <= pend_d;
      evt_cnt_q  <= evt_cnt_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.edge_pol = edge_pol_q;
  assign bus.pend     = pend_q;
  assign bus.evt_cnt  = evt_cnt_q;

endmodule
